alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX boundary of the 16-bit pipeline; the producer side of the ALU operand/opcode interface.
- Registers decoded instructions and drives the ALU's first/second/op inputs, with EX/MEM and MEM/WB forwarding applied.
- Detects load-use hazards, inserts bubbles, honours downstream stall and branch flush, and backpressures decode.

Parameters:
- DATA_W, 16, operand/result width.
- REG_AW, 3, register address width (R0..R7).
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  this stage accepts the decode instruction this cycle
- dec_op  in  OP_W  ALU opcode
- dec_rs_addr / dec_rt_addr  in  REG_AW  source register addresses
- dec_rs_used / dec_rt_used  in  1  source actually read
- dec_rs_data / dec_rt_data  in  DATA_W  register-file read data
- dec_imm  in  DATA_W  sign/zero-extended immediate
- dec_use_imm  in  1  second operand is the immediate
- dec_wr_en / dec_wr_addr  in  1 / REG_AW  destination register
- dec_is_load  in  1  instruction is a memory load
- exmem_wr_en / exmem_wr_addr / exmem_data  in  1 / REG_AW / DATA_W  EX/MEM forward source
- memwb_wr_en / memwb_wr_addr / memwb_data  in  1 / REG_AW / DATA_W  MEM/WB forward source
- stall  in  1  downstream stall; hold the stage
- flush  in  1  branch taken; squash
- alu_first / alu_second  out  DATA_W  ALU operands after forwarding
- alu_op  out  OP_W  ALU opcode
- ex_valid / ex_wr_en / ex_wr_addr / ex_is_load  out  1 / 1 / REG_AW / 1  EX-stage sideband

Behaviour:
- Reset (rst=0, async): all stage registers 0; ex_valid=0, ex_wr_en=0, ex_is_load=0; alu_op=4'b1000 (ZERO); alu_first=alu_second=0.
- Bubble: valid=0, wr_en=0, is_load=0, op=4'b1000, operands 0, used flags 0.
- hazard (comb) = ex_valid & ex_is_load & ex_wr_en & dec_valid & ((dec_rs_used & dec_rs_addr==ex_wr_addr) | (dec_rt_used & dec_rt_addr==ex_wr_addr)).
- dec_ready (comb) = !stall & !hazard. It does not depend on flush; a flushed decode instruction is consumed and discarded.
- Register update per clk edge, in priority order:
  - flush → load bubble. Flush overrides stall.
  - stall → hold all state.
  - hazard → load bubble; decode holds its instruction and retries next cycle.
  - dec_valid → capture the instruction.
  - otherwise → load bubble.
- Capture write-through: if memwb_wr_en & memwb_wr_addr==dec_rs_addr, register memwb_data instead of dec_rs_data. Same rule for rt.
- Output forwarding (comb, on registered ex_rs/ex_rt):
  - src_a = exmem_data if ex_rs_used & exmem_wr_en & exmem_wr_addr==ex_rs_addr.
  - else memwb_data if the same match holds on the MEM/WB port.
  - else the registered data. EX/MEM has priority over MEM/WB.
  - alu_first = src_a. alu_second = ex_use_imm ? ex_imm : forwarded rt (same rule).
- Latency: one cycle decode→EX. Back-to-back issue at full rate absent hazard/stall.
- Load-use costs exactly one bubble. The next cycle, the load has moved to EX/MEM, and its data arrives via the MEM/WB path one cycle later; the memory stage stalls if data is not ready.
- No forwarding from R0 special case; all registers are treated equal.
- Reset mid-stall or mid-hazard: the stage returns immediately to the bubble state; dec_ready follows its combinational definition.

Decomposition:
- alu_pkg holds:
  - opcode constants: ADD 0000, SUB 0001, AND 0010, OR 0011, NOT 0100, SRA 0101, SLL 0110, SLT 0111, ZERO 1000, PASSA 1001, LNOT 1010, NEQ 1011, PASSB 1100.
  - BUBBLE_OP=ZERO, DATA_W, REG_AW, OP_W.
- One sub-module, operand_forward_mux (address compare plus 3:1 select), instantiated for rs and rt.

Test Plan:
- Reset: hold rst=0 with arbitrary dec inputs → ex_valid=0, alu_op=4'b1000, alu_first=alu_second=0; release rst → first valid decode is captured the next edge.
- Plain issue: ADD rs=R1(0x0005), rt=R2(0x0003), no forwarding → next cycle alu_op=0000, alu_first=0x0005, alu_second=0x0003, ex_valid=1.
- Forwarding priority: EX holds rs=R3 (stale 0x1111); exmem writes R3=0x2222 and memwb writes R3=0x3333 → alu_first=0x2222. With exmem_wr_en=0 → alu_first=0x3333.
- Load-use: EX holds load to R4; decode SUB reads R4 → dec_ready=0 for one cycle, a bubble is issued (alu_op=1000, ex_valid=0), then SUB issues with dec_ready=1.
- Stall vs flush: stall=1 for 3 cycles → outputs held, dec_ready=0. stall=1 & flush=1 simultaneously → bubble loaded next edge.
- Immediate and write-through: dec_use_imm=1, imm=0xFFF0, and memwb writes R1=0x0042 in the capture cycle with rs=R1 → alu_first=0x0042, alu_second=0xFFF0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes and the ID/EX register layout of the 16-bit pipeline.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOT   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_ZERO  = 4'b1000;
  localparam logic [OP_W-1:0] OP_PASSA = 4'b1001;
  localparam logic [OP_W-1:0] OP_LNOT  = 4'b1010;
  localparam logic [OP_W-1:0] OP_NEQ   = 4'b1011;
  localparam logic [OP_W-1:0] OP_PASSB = 4'b1100;

  localparam logic [OP_W-1:0] BUBBLE_OP = OP_ZERO;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic              is_load;
  } ex_stage_t;

  // Everything zero except the opcode, so an idle ALU computes ZERO.
  function automatic ex_stage_t bubble();
    ex_stage_t b;
    b    = '0;
    b.op = BUBBLE_OP;
    return b;
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Selects one ALU operand from EX/MEM, MEM/WB or the registered value (EX/MEM wins).
module operand_forward_mux
  import alu_pkg::*;
(
  input  logic              src_used,
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              exmem_wr_en,
  input  logic [REG_AW-1:0] exmem_wr_addr,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [REG_AW-1:0] memwb_wr_addr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] fwd_data
);

  always_comb begin
    fwd_data = src_data;
    if (src_used && exmem_wr_en && (exmem_wr_addr == src_addr)) begin
      fwd_data = exmem_data;
    end else if (src_used && memwb_wr_en && (memwb_wr_addr == src_addr)) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register driving the ALU, with forwarding, load-use bubbles,
// stall hold and flush squash.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [REG_AW-1:0] dec_rs_addr,
  input  logic [REG_AW-1:0] dec_rt_addr,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic [DATA_W-1:0] dec_rs_data,
  input  logic [DATA_W-1:0] dec_rt_data,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic              dec_use_imm,
  input  logic              dec_wr_en,
  input  logic [REG_AW-1:0] dec_wr_addr,
  input  logic              dec_is_load,
  input  logic              exmem_wr_en,
  input  logic [REG_AW-1:0] exmem_wr_addr,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [REG_AW-1:0] memwb_wr_addr,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_first,
  output logic [DATA_W-1:0] alu_second,
  output logic [OP_W-1:0]   alu_op,
  output logic              ex_valid,
  output logic              ex_wr_en,
  output logic [REG_AW-1:0] ex_wr_addr,
  output logic              ex_is_load
);

  ex_stage_t ex_q, ex_d, capture;
  logic hazard;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  assign hazard = ex_q.valid && ex_q.is_load && ex_q.wr_en && dec_valid &&
                  ((dec_rs_used && (dec_rs_addr == ex_q.wr_addr)) ||
                   (dec_rt_used && (dec_rt_addr == ex_q.wr_addr)));

  assign dec_ready = !stall && !hazard;

  // MEM/WB writes the register file in the same cycle it is read, so pass it through.
  always_comb begin
    capture         = '0;
    capture.valid   = 1'b1;
    capture.op      = dec_op;
    capture.rs_addr = dec_rs_addr;
    capture.rt_addr = dec_rt_addr;
    capture.rs_used = dec_rs_used;
    capture.rt_used = dec_rt_used;
    capture.rs_data = (memwb_wr_en && (memwb_wr_addr == dec_rs_addr)) ? memwb_data : dec_rs_data;
    capture.rt_data = (memwb_wr_en && (memwb_wr_addr == dec_rt_addr)) ? memwb_data : dec_rt_data;
    capture.imm     = dec_imm;
    capture.use_imm = dec_use_imm;
    capture.wr_en   = dec_wr_en;
    capture.wr_addr = dec_wr_addr;
    capture.is_load = dec_is_load;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble();
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = bubble();
    end else if (dec_valid) begin
      ex_d = capture;
    end else begin
      ex_d = bubble();
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= bubble();
    end else begin
      ex_q <= ex_d;
    end
  end

  operand_forward_mux u_fwd_rs (
    .src_used      (ex_q.rs_used),
    .src_addr      (ex_q.rs_addr),
    .src_data      (ex_q.rs_data),
    .exmem_wr_en   (exmem_wr_en),
    .exmem_wr_addr (exmem_wr_addr),
    .exmem_data    (exmem_data),
    .memwb_wr_en   (memwb_wr_en),
    .memwb_wr_addr (memwb_wr_addr),
    .memwb_data    (memwb_data),
    .fwd_data      (rs_fwd)
  );

  operand_forward_mux u_fwd_rt (
    .src_used      (ex_q.rt_used),
    .src_addr      (ex_q.rt_addr),
    .src_data      (ex_q.rt_data),
    .exmem_wr_en   (exmem_wr_en),
    .exmem_wr_addr (exmem_wr_addr),
    .exmem_data    (exmem_data),
    .memwb_wr_en   (memwb_wr_en),
    .memwb_wr_addr (memwb_wr_addr),
    .memwb_data    (memwb_data),
    .fwd_data      (rt_fwd)
  );

  assign alu_first  = rs_fwd;
  assign alu_second = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign alu_op     = ex_q.op;
  assign ex_valid   = ex_q.valid;
  assign ex_wr_en   = ex_q.wr_en;
  assign ex_wr_addr = ex_q.wr_addr;
  assign ex_is_load = ex_q.is_load;

endmodule
